// File: rtl/mac_tile_scheduler.sv
// Tile command scheduler for a hypervector-encoder MAC array.
// Walks the feature axis in N_SIZE tiles inside each M_SIZE row group and
// waits for the MAC to report each finished row group before moving on.
// Optional feature: define SCHED_PERF_CNT_EN to add the stall_cycles counter.
module mac_tile_scheduler #(
  parameter int DHV_SIZE = 4000,
  parameter int DIV_SIZE = 512,
  parameter int N_SIZE   = 16,
  parameter int M_SIZE   = 16
) (
  input  logic                        clk,
  input  logic                        reset_in,
  input  logic                        start,
  input  logic                        abort,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [$clog2(DIV_SIZE)-1:0] cmd_x,
  output logic [$clog2(DHV_SIZE)-1:0] cmd_y,
  output logic                        cmd_first,
  output logic                        cmd_last,
  input  logic                        mac_done,
  output logic                        busy,
  output logic                        all_done
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                 stall_cycles
`endif
);

  localparam int XW = $clog2(DIV_SIZE);
  localparam int YW = $clog2(DHV_SIZE);
  localparam logic [XW-1:0] X_LAST = XW'(DIV_SIZE - N_SIZE);
  localparam logic [XW-1:0] X_STEP = XW'(N_SIZE);
  localparam logic [YW-1:0] Y_LAST = YW'(DHV_SIZE - M_SIZE);
  localparam logic [YW-1:0] Y_STEP = YW'(M_SIZE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    FINISH    = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [XW-1:0]   x_reg, x_next;
  logic [YW-1:0]   y_reg, y_next;

  // State and tile/row counters; reset forces an idle scheduler at once.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
    end
  end

  // Next-state and counter update; abort beats any handshake or mac_done.
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          state_next = ISSUE;
          x_next     = '0;
          y_next     = '0;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (cmd_ready) begin
          if (x_reg == X_LAST) begin
            state_next = WAIT_DONE;
          end else begin
            x_next = x_reg + X_STEP;
          end
        end
      end
      WAIT_DONE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (mac_done) begin
          if (y_reg < Y_LAST) begin
            y_next     = y_reg + Y_STEP;
            x_next     = '0;
            state_next = ISSUE;
          end else begin
            state_next = FINISH;
          end
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decode straight from state so reset takes effect immediately.
  assign cmd_valid = (state_reg == ISSUE);
  assign busy      = (state_reg != IDLE);
  assign all_done  = (state_reg == FINISH);
  assign cmd_x     = x_reg;
  assign cmd_y     = y_reg;
  assign cmd_first = (x_reg == '0);
  assign cmd_last  = (x_reg == X_LAST);

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] stall_reg;
  logic        start_accept;
  logic        stall_now;

  assign start_accept = (state_reg == IDLE) && start && !abort;
  assign stall_now    = ((state_reg == ISSUE) && !cmd_ready) ||
                        (state_reg == WAIT_DONE);

  // Saturating stall counter, cleared whenever a new pass is accepted.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      stall_reg <= '0;
    end else if (start_accept) begin
      stall_reg <= '0;
    end else if (stall_now && (stall_reg != 32'hFFFF_FFFF)) begin
      stall_reg <= stall_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_mac_tile_scheduler.sv
// Scoreboard bench for mac_tile_scheduler at default parameters.
module tb_mac_tile_scheduler;

  localparam int DHV = 4000;
  localparam int DIV = 512;
  localparam int NS  = 16;
  localparam int MS  = 16;
  localparam int XW  = $clog2(DIV);
  localparam int YW  = $clog2(DHV);

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          f;
    logic          l;
  } cmd_t;

  logic          clk = 1'b0;
  logic          reset_in;
  logic          start, abort, cmd_ready;
  logic          mac_done_auto, mac_done_man;
  logic          cmd_valid, cmd_first, cmd_last, busy, all_done;
  logic [XW-1:0] cmd_x;
  logic [YW-1:0] cmd_y;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  cmd_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hs_cnt  = 0;
  int   ad_cnt  = 0;
  int   mac_cd  = 0;
  int   hold_y  = -1;
  logic [XW-1:0] last_x;
  logic [YW-1:0] last_y;

  always #5 clk = ~clk;

  mac_tile_scheduler #(
    .DHV_SIZE(DHV), .DIV_SIZE(DIV), .N_SIZE(NS), .M_SIZE(MS)
  ) dut (
    .clk       (clk),
    .reset_in  (reset_in),
    .start     (start),
    .abort     (abort),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_first (cmd_first),
    .cmd_last  (cmd_last),
    .mac_done  (mac_done_auto | mac_done_man),
    .busy      (busy),
    .all_done  (all_done)
`ifdef SCHED_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected command stream of one complete pass.
  task automatic push_pass();
    cmd_t c;
    for (int y = 0; y <= DHV - MS; y += MS) begin
      for (int x = 0; x <= DIV - NS; x += NS) begin
        c.x = XW'(x);
        c.y = YW'(y);
        c.f = (x == 0);
        c.l = (x == DIV - NS);
        exp_q.push_back(c);
      end
    end
  endtask

  // Monitor + MAC responder, sampled on the falling edge.
  initial begin
    cmd_t e;
    mac_done_auto = 1'b0;
    forever begin
      @(negedge clk);
      mac_done_auto = 1'b0;
      if (mac_cd > 0) begin
        mac_cd--;
        if (mac_cd == 0) mac_done_auto = 1'b1;
      end
      if (all_done) ad_cnt++;
      if (reset_in && cmd_valid && cmd_ready) begin
        hs_cnt++;
        last_x = cmd_x;
        last_y = cmd_y;
        if (exp_q.size() == 0) begin
          check_val("cmd_unexpected", 64'(cmd_x), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check_val("cmd", 64'({cmd_x, cmd_y, cmd_first, cmd_last}), 64'(e));
        end
        if (cmd_last) begin
          $display("[TB] row group y=%0d issued (%0d commands so far)", cmd_y, hs_cnt);
          if (int'(cmd_y) != hold_y) mac_cd = 2;
        end
      end
    end
  end

  initial begin
    int hs0, ad0;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] st0;
`endif
    reset_in = 1'b0; start = 1'b0; abort = 1'b0; cmd_ready = 1'b1; mac_done_man = 1'b0;

    // Reset state
    #12;
    check_val("rst_busy", 64'(busy), 0);
    check_val("rst_valid", 64'(cmd_valid), 0);
    check_val("rst_all_done", 64'(all_done), 0);
    check_val("rst_x", 64'(cmd_x), 0);
    check_val("rst_y", 64'(cmd_y), 0);
`ifdef SCHED_PERF_CNT_EN
    check_val("rst_stall", 64'(stall_cycles), 0);
`endif
    @(negedge clk);
    reset_in = 1'b1;

    // Full pass at full throughput
    hs0 = hs_cnt; ad0 = ad_cnt;
    push_pass();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 20000 && ad_cnt == ad0; i++) @(negedge clk);
    check_val("full_timeout", 64'(ad_cnt != ad0), 1);
    repeat (4) @(negedge clk);
    check_val("full_hs", 64'(hs_cnt - hs0), 8000);
    check_val("full_last_x", 64'(last_x), 496);
    check_val("full_last_y", 64'(last_y), 3984);
    check_val("full_all_done", 64'(ad_cnt - ad0), 1);
    check_val("full_queue", 64'(exp_q.size()), 0);
    check_val("full_idle", 64'(busy), 0);
    $display("[TB] full pass: %0d commands, all_done pulses %0d", hs_cnt - hs0, ad_cnt - ad0);

    // Stall on the second tile, then abort in WAIT_DONE of row group 3
    hold_y = 48;
    push_pass();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check_val("start_first_x", 64'(cmd_x), 0);
    check_val("start_first_valid", 64'(cmd_valid), 1);
    @(posedge clk); #1 cmd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
`ifdef SCHED_PERF_CNT_EN
      if (k == 0) st0 = stall_cycles;
`endif
      check_val("stall_hold", 64'({cmd_valid, cmd_x, cmd_y, cmd_first, cmd_last}),
                64'({1'b1, XW'(16), YW'(0), 1'b0, 1'b0}));
    end
    @(posedge clk); #1 cmd_ready = 1'b1;
    @(negedge clk);
`ifdef SCHED_PERF_CNT_EN
    check_val("stall_count", 64'(stall_cycles - st0), 5);
`endif
    $display("[TB] stall of 5 cycles on tile x=16 y=0");
    for (int i = 0; i < 2000 && !(busy && !cmd_valid && cmd_y == YW'(48)); i++) @(negedge clk);
    check_val("wait_rg3_reached", 64'(busy && !cmd_valid && cmd_y == YW'(48)), 1);
    ad0 = ad_cnt;
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check_val("abort_busy", 64'(busy), 0);
    check_val("abort_valid", 64'(cmd_valid), 0);
    repeat (5) @(negedge clk);
    check_val("abort_no_done", 64'(ad_cnt - ad0), 0);
    exp_q.delete();
    hold_y = -1;
    $display("[TB] abort in WAIT_DONE at y=48");

    // Restart after abort; stray start/mac_done during ISSUE
    hs0 = hs_cnt;
    push_pass();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 50 && (hs_cnt - hs0) < 3; i++) @(negedge clk);
    check_val("restart_hs", 64'((hs_cnt - hs0) >= 3), 1);
    @(posedge clk); #1 cmd_ready = 1'b0;
    @(negedge clk);
    x0 = cmd_x; y0 = cmd_y;
    @(posedge clk); #1 start = 1'b1; mac_done_man = 1'b1;
    @(posedge clk); #1 start = 1'b0; mac_done_man = 1'b0;
    @(negedge clk);
    check_val("stray_hold", 64'({cmd_valid, busy, cmd_x, cmd_y}), 64'({2'b11, x0, y0}));
    $display("[TB] stray start/mac_done ignored at x=%0d y=%0d", x0, y0);

    // Asynchronous reset mid-ISSUE with no clock edge
    #2 reset_in = 1'b0;
    #1;
    check_val("arst_outs", 64'({busy, cmd_valid, all_done, cmd_x, cmd_y}), 0);
    #1 reset_in = 1'b1;
    exp_q.delete();
    cmd_ready = 1'b1;
    $display("[TB] async reset mid-ISSUE");

    // start together with abort in IDLE
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_val("start_abort_idle", 64'({busy, cmd_valid}), 0);
    $display("[TB] start+abort in IDLE stays idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_tile_scheduler.md
MAC_TILE_SCHEDULER -- requirements
Module: mac_tile_scheduler

Interface
- REQ-001: Parameter DHV_SIZE, default 4000: hypervector dimensions; SHALL be a multiple of M_SIZE.
- REQ-002: Parameter DIV_SIZE, default 512: input feature count; SHALL be a multiple of N_SIZE.
- REQ-003: Parameter N_SIZE, default 16: features consumed per MAC tile.
- REQ-004: Parameter M_SIZE, default 16: dimensions produced per MAC row group.
- REQ-005: Port clk, input, 1 bit: the only clock.
- REQ-006: Port reset_in, input, 1 bit: asynchronous, active-low reset.
- REQ-007: Port start, input, 1 bit: begin a full encode pass.
- REQ-008: Port abort, input, 1 bit: cancel the pass in progress.
- REQ-009: Port cmd_valid, output, 1 bit: tile command valid.
- REQ-010: Port cmd_ready, input, 1 bit: MAC accepts the command.
- REQ-011: Port cmd_x, output, $clog2(DIV_SIZE) bits: feature offset of the tile.
- REQ-012: Port cmd_y, output, $clog2(DHV_SIZE) bits: dimension offset of the row group.
- REQ-013: Port cmd_first, output, 1 bit: first tile of the row group (MAC clears its accumulator).
- REQ-014: Port cmd_last, output, 1 bit: last tile of the row group.
- REQ-015: Port mac_done, input, 1 bit: one-cycle pulse; the MAC has written the row-group result.
- REQ-016: Port busy, output, 1 bit: high in every state except IDLE.
- REQ-017: Port all_done, output, 1 bit: one-cycle pulse when the pass completes.

Function
- REQ-018: The FSM SHALL have four states: IDLE, ISSUE, WAIT_DONE, FINISH.
- REQ-019: IDLE -> ISSUE on start; cmd_x and cmd_y load 0.
- REQ-020: In ISSUE, cmd_valid=1; cmd_x, cmd_y, cmd_first and cmd_last SHALL stay stable while cmd_valid && !cmd_ready.
- REQ-021: On handshake with cmd_x < DIV_SIZE-N_SIZE: cmd_x += N_SIZE, the FSM stays in ISSUE, and the next command is presented the following cycle (one tile per cycle at full throughput).
- REQ-022: On handshake with cmd_x == DIV_SIZE-N_SIZE: go to WAIT_DONE with cmd_valid=0.
- REQ-023: cmd_first = (cmd_x==0); cmd_last = (cmd_x==DIV_SIZE-N_SIZE); both are combinational from the counters and valid only when qualified by cmd_valid.
- REQ-024: In WAIT_DONE, on mac_done:
  - if cmd_y < DHV_SIZE-M_SIZE: cmd_y += M_SIZE, cmd_x = 0, go to ISSUE;
  - else go to FINISH.
- REQ-025: FINISH SHALL last exactly one cycle with all_done=1, then go to IDLE.
- REQ-026: mac_done outside WAIT_DONE is ignored.
- REQ-027: start outside IDLE is ignored.
- REQ-028: abort in any non-IDLE state forces IDLE next cycle: cmd_valid=0, no all_done. Abort takes priority over a simultaneous handshake or mac_done.
- REQ-029: start and abort asserted together in IDLE: remain in IDLE.
- REQ-030: The total pass is (DHV_SIZE/M_SIZE) row groups × (DIV_SIZE/N_SIZE) tiles; defaults give 250 × 32 = 8000 commands.

Reset
- REQ-031: While reset_in is low, regardless of clk: state=IDLE; cmd_x=0, cmd_y=0, cmd_valid=0, busy=0, all_done=0.
- REQ-032: Assertion of reset_in mid-pass SHALL abandon the pass; no partial all_done is produced.
- REQ-033: Deassertion of reset_in SHALL be treated as synchronised externally; the first start is accepted on the first rising edge after release.

Configuration
- REQ-034: Macro SCHED_PERF_CNT_EN defined: add output stall_cycles (32 bits). It counts cycles in ISSUE with cmd_valid && !cmd_ready plus cycles in WAIT_DONE, clears on start accepted and on reset, and saturates at 2^32-1.
- REQ-035: Macro SCHED_PERF_CNT_EN undefined: the port and the counter SHALL be absent, with identical behaviour on all other ports.

Verification
- REQ-036: Defaults, cmd_ready tied 1, mac_done pulsed 2 cycles after each cmd_last -> 8000 handshakes; last command cmd_x=496, cmd_y=3984; exactly one all_done pulse.
- REQ-037: DIV_SIZE=32, DHV_SIZE=32 -> command sequence (x,y,first,last) = (0,0,1,0), (16,0,0,1), (0,16,1,0), (16,16,0,1), then all_done.
- REQ-038: cmd_ready held low 5 cycles on the second tile -> the command is held stable for 5 cycles; with SCHED_PERF_CNT_EN, stall_cycles increments by 5 for that stall.
- REQ-039: abort asserted in WAIT_DONE of row group 3 -> IDLE next cycle, busy=0, no all_done; a following start restarts at cmd_x=0, cmd_y=0.
- REQ-040: reset_in pulsed low mid-ISSUE without a clock edge -> outputs take reset values immediately.
- REQ-041: mac_done and start pulsed in ISSUE -> no state change; cmd_x advances only on handshake.
